// File: rtl/vga_pkg.sv
// Shared constants, types and PMOD packing helper for the VGA test-pattern source.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FRONT  = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BACK   = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FRONT  = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BACK   = 33;

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned FCNT_W = 8;
  localparam int unsigned PMOD_W = 8;

  // TinyVGA PMOD bit positions
  localparam int unsigned PMOD_HSYNC = 7;
  localparam int unsigned PMOD_B0    = 6;
  localparam int unsigned PMOD_G0    = 5;
  localparam int unsigned PMOD_R0    = 4;
  localparam int unsigned PMOD_VSYNC = 3;
  localparam int unsigned PMOD_B1    = 2;
  localparam int unsigned PMOD_G1    = 1;
  localparam int unsigned PMOD_R1    = 0;

  localparam logic [PMOD_W-1:0] PMOD_IDLE = 8'h88;

  typedef enum logic [1:0] {
    PAT_BLACK = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_GRAD  = 2'd3
  } pattern_e;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb_t;

  function automatic logic [PMOD_W-1:0] pmod_pack(input logic hsync_n, input logic vsync_n,
                                                   input rgb_t c);
    logic [PMOD_W-1:0] p;
    p             = '0;
    p[PMOD_HSYNC] = hsync_n;
    p[PMOD_VSYNC] = vsync_n;
    p[PMOD_R0]    = c.r[0];
    p[PMOD_G0]    = c.g[0];
    p[PMOD_B0]    = c.b[0];
    p[PMOD_R1]    = c.r[1];
    p[PMOD_G1]    = c.g[1];
    p[PMOD_B1]    = c.b[1];
    return p;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with sync, active-area and wrap decode.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACT = H_ACTIVE,
  parameter int unsigned H_FP  = H_FRONT,
  parameter int unsigned H_SW  = H_SYNC,
  parameter int unsigned H_BP  = H_BACK,
  parameter int unsigned V_ACT = V_ACTIVE,
  parameter int unsigned V_FP  = V_FRONT,
  parameter int unsigned V_SW  = V_SYNC,
  parameter int unsigned V_BP  = V_BACK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  output logic [CNT_W-1:0] h_o,
  output logic [CNT_W-1:0] v_o,
  output logic             hsync_n_c_o,
  output logic             vsync_n_c_o,
  output logic             active_c_o,
  output logic             wrap_c_o
);

  localparam int unsigned HT     = H_ACT + H_FP + H_SW + H_BP;
  localparam int unsigned VT     = V_ACT + V_FP + V_SW + V_BP;
  localparam int unsigned HS_BEG = H_ACT + H_FP;
  localparam int unsigned HS_END = HS_BEG + H_SW;
  localparam int unsigned VS_BEG = V_ACT + V_FP;
  localparam int unsigned VS_END = VS_BEG + V_SW;

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic             h_last, v_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Raster advance; vertical steps only on the last pixel of a line
  always_comb begin
    h_last = (h_q == CNT_W'(HT - 1));
    v_last = (v_q == CNT_W'(VT - 1));
    h_d    = h_q;
    v_d    = v_q;
    if (enable_i) begin
      if (h_last) begin
        h_d = '0;
        v_d = v_last ? '0 : v_q + CNT_W'(1);
      end else begin
        h_d = h_q + CNT_W'(1);
      end
    end
  end

  assign hsync_n_c_o = !((h_q >= CNT_W'(HS_BEG)) && (h_q < CNT_W'(HS_END)));
  assign vsync_n_c_o = !((v_q >= CNT_W'(VS_BEG)) && (v_q < CNT_W'(VS_END)));
  assign active_c_o  = (h_q < CNT_W'(H_ACT)) && (v_q < CNT_W'(V_ACT));
  assign wrap_c_o    = h_last && v_last;
  assign h_o         = h_q;
  assign v_o         = v_q;

endmodule

// File: rtl/vga_pmod_source.sv
// 640x480@60 VGA source: test-pattern generator packed onto a TinyVGA PMOD byte.
module vga_pmod_source
  import vga_pkg::*;
#(
  parameter int unsigned V_ACT = V_ACTIVE,
  parameter int unsigned V_FP  = V_FRONT,
  parameter int unsigned V_SW  = V_SYNC,
  parameter int unsigned V_BP  = V_BACK
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [1:0]        pattern_sel,
  output logic [PMOD_W-1:0] uo_pmod,
  output logic [CNT_W-1:0]  pix_x,
  output logic [CNT_W-1:0]  pix_y,
  output logic              video_active,
  output logic              frame_start
);

  logic              hsync_n, vsync_n, wrap, wrap_en;
  pattern_e          pat_q, pat_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [PMOD_W-1:0] pmod_q, pmod_d;
  logic              fs_q, fs_d;
  rgb_t              rgb;
  logic              unused_fcnt_c;

  vga_timing #(
    .V_ACT(V_ACT),
    .V_FP (V_FP),
    .V_SW (V_SW),
    .V_BP (V_BP)
  ) u_timing (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_i   (enable),
    .h_o        (pix_x),
    .v_o        (pix_y),
    .hsync_n_c_o(hsync_n),
    .vsync_n_c_o(vsync_n),
    .active_c_o (video_active),
    .wrap_c_o   (wrap)
  );

  assign wrap_en       = enable && wrap;
  assign unused_fcnt_c = ^{fcnt_q[7:6], fcnt_q[3:0]};

  // Colour for the pixel the counters currently address; blanked outside the active area
  always_comb begin
    rgb = '0;
    case (pat_q)
      PAT_BARS: begin
        rgb.r = {2{pix_x[8]}};
        rgb.g = {2{pix_x[7]}};
        rgb.b = {2{pix_x[6]}};
      end
      PAT_CHECK: begin
        if (pix_x[5] ^ pix_y[5]) rgb = '1;
      end
      PAT_GRAD: begin
        rgb.r = pix_x[7:6];
        rgb.g = pix_y[7:6];
        rgb.b = fcnt_q[5:4];
      end
      default: rgb = '0;
    endcase
    if (!video_active) rgb = '0;
  end

  // Pattern and frame count only move at the frame wrap so a frame never tears
  always_comb begin
    pat_d  = pat_q;
    fcnt_d = fcnt_q;
    pmod_d = pmod_q;
    fs_d   = wrap_en;
    if (enable) pmod_d = pmod_pack(hsync_n, vsync_n, rgb);
    if (wrap_en) begin
      pat_d  = pattern_e'(pattern_sel);
      fcnt_d = fcnt_q + FCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q  <= PAT_BLACK;
      fcnt_q <= '0;
      pmod_q <= PMOD_IDLE;
      fs_q   <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      fcnt_q <= fcnt_d;
      pmod_q <= pmod_d;
      fs_q   <= fs_d;
    end
  end

  assign uo_pmod     = pmod_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_pmod_source.sv
// Self-checking bench for vga_pmod_source with a shortened vertical raster.
module tb_vga_pmod_source;

  localparam int HT    = 800;
  localparam int VA    = 33;
  localparam int VFP   = 1;
  localparam int VSW   = 1;
  localparam int VBP   = 1;
  localparam int VT    = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam int NV    = 10;

  logic       clk, rst_n, enable;
  logic [1:0] pattern_sel;
  logic [7:0] uo_pmod;
  logic [9:0] pix_x, pix_y;
  logic       video_active, frame_start;

  vga_pmod_source #(
    .V_ACT(VA), .V_FP(VFP), .V_SW(VSW), .V_BP(VBP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .uo_pmod     (uo_pmod),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .video_active(video_active),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: linear raster position plus latched pattern / frame count
  int         m_pos, m_pat, m_fc, m_frames;
  logic [7:0] m_uo;
  logic       m_fs;
  int         seg_bad;
  logic [29:0] seg_got, seg_exp;
  int         wrap_sel[4] = '{1, 2, 3, 0};

  function automatic logic [7:0] ref_pmod(input int x, input int y, input int pat, input int fc);
    int hs, vs, r, g, b;
    hs = (x >= 656 && x < 752) ? 0 : 1;
    vs = (y >= VA + VFP && y < VA + VFP + VSW) ? 0 : 1;
    r = 0; g = 0; b = 0;
    if (x < 640 && y < VA) begin
      case (pat)
        1: begin r = ((x / 256) % 2) * 3; g = ((x / 128) % 2) * 3; b = ((x / 64) % 2) * 3; end
        2: if (((x / 32) % 2) != ((y / 32) % 2)) begin r = 3; g = 3; b = 3; end
        3: begin r = (x / 64) % 4; g = (y / 64) % 4; b = (fc / 16) % 4; end
        default: ;
      endcase
    end
    return 8'(hs * 128 + (b % 2) * 64 + (g % 2) * 32 + (r % 2) * 16 +
              vs * 8 + (b / 2) * 4 + (g / 2) * 2 + (r / 2));
  endfunction

  task automatic model_reset();
    m_pos = 0; m_pat = 0; m_fc = 0; m_frames = 0; m_uo = 8'h88; m_fs = 1'b0;
  endtask

  task automatic model_edge(input logic en, input logic [1:0] sel);
    if (en) begin
      m_uo = ref_pmod(m_pos % HT, m_pos / HT, m_pat, m_fc);
      m_fs = (m_pos == FRAME - 1);
      if (m_fs) begin
        m_pat = int'(sel);
        m_fc = (m_fc + 1) % 256;
        m_frames++;
      end
      m_pos = (m_pos + 1) % FRAME;
    end else begin
      m_fs = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic step(input logic en, input logic [1:0] sel);
    logic [29:0] got, expv;
    logic        va;
    enable = en;
    pattern_sel = sel;
    @(posedge clk);
    model_edge(en, sel);
    #1;
    va = (m_pos % HT < 640) && (m_pos / HT < VA);
    got  = {uo_pmod, pix_x, pix_y, video_active, frame_start};
    expv = {m_uo, 10'(m_pos % HT), 10'(m_pos / HT), va, m_fs};
    if (got !== expv) begin
      if (seg_bad == 0) begin seg_got = got; seg_exp = expv; end
      seg_bad++;
    end
  endtask

  task automatic seg_end(input string name);
    vectors++;
    if (seg_bad != 0) begin
      miscompares++;
      $display("FAIL %s: %0d cycles off model, first {uo,x,y,va,fs} got 0x%0h required 0x%0h",
               name, seg_bad, seg_got, seg_exp);
    end
    seg_bad = 0;
  endtask

  // Run with rare random stalls and random pattern_sel except at the wrap cycle
  task automatic goto(input int f, input int x, input int y);
    int budget;
    logic [1:0] sel;
    budget = 2 * FRAME;
    while (!(m_frames == f && m_pos == y * HT + x) && budget > 0) begin
      sel = (m_pos == FRAME - 1) ? 2'(wrap_sel[m_frames % 4]) : 2'($urandom_range(0, 3));
      step($urandom_range(0, 127) != 0, sel);
      budget--;
    end
    if (budget == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL goto_f%0d_x%0d_y%0d: position not reached, got pos %0d required %0d",
               f, x, y, m_pos, y * HT + x);
    end
  endtask

  typedef struct {
    int         f;
    int         x;
    int         y;
    logic [7:0] uo;
  } vec_t;

  vec_t tbl[NV];

  initial begin
    int first_hs, hs_rise, hs_second, vs_low, vs_rise, fs_at, fs_x, fs_y;
    logic prev_hs, prev_vs;
    logic [9:0] hx, hy;
    logic [7:0] huo;
    int hold_bad, fs_seen;

    tbl[0] = '{1,  70,  0, 8'hCC};
    tbl[1] = '{1, 450,  0, 8'hFF};
    tbl[2] = '{1, 645,  0, 8'h88};
    tbl[3] = '{1, 300,  3, 8'h99};
    tbl[4] = '{2,   0,  0, 8'h88};
    tbl[5] = '{2,  32,  0, 8'hFF};
    tbl[6] = '{2,  32, 32, 8'h88};
    tbl[7] = '{2,  64, 32, 8'hFF};
    tbl[8] = '{3, 200,  0, 8'h99};
    tbl[9] = '{3, 100,  2, 8'h98};

    seg_bad = 0; seg_got = '0; seg_exp = '0;
    rst_n = 1'b0; enable = 1'b0; pattern_sel = 2'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_uo", 32'(uo_pmod), 32'h88);
    check("reset_x", 32'(pix_x), 0);
    check("reset_y", 32'(pix_y), 0);
    check("reset_fs", 32'(frame_start), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("pre_edge_uo", 32'(uo_pmod), 32'h88);

    // First frame with enable held: measure sync and frame_start edges
    first_hs = -1; hs_rise = -1; hs_second = -1; vs_low = -1; vs_rise = -1;
    fs_at = -1; fs_x = -1; fs_y = -1;
    prev_hs = 1'b1; prev_vs = 1'b1;
    for (int e = 1; e <= FRAME + 10 && fs_at < 0; e++) begin
      step(1'b1, 2'd1);
      if (prev_hs && !uo_pmod[7]) begin
        if (first_hs < 0) first_hs = e;
        else if (hs_second < 0) hs_second = e;
      end
      if (!prev_hs && uo_pmod[7] && hs_rise < 0) hs_rise = e;
      if (prev_vs && !uo_pmod[3] && vs_low < 0) vs_low = e;
      if (!prev_vs && uo_pmod[3] && vs_rise < 0) vs_rise = e;
      if (frame_start) begin fs_at = e; fs_x = int'(pix_x); fs_y = int'(pix_y); end
      prev_hs = uo_pmod[7];
      prev_vs = uo_pmod[3];
    end
    check("hsync_first_low_edge", 32'(first_hs), 657);
    check("hsync_width", 32'(hs_rise - first_hs), 96);
    check("hsync_period", 32'(hs_second - first_hs), 800);
    check("vsync_first_low_edge", 32'(vs_low), 32'((VA + VFP) * HT + 1));
    check("vsync_width", 32'(vs_rise - vs_low), 32'(VSW * HT));
    check("frame_start_edge", 32'(fs_at), 32'(FRAME));
    check("frame_start_x", 32'(fs_x), 0);
    check("frame_start_y", 32'(fs_y), 0);
    step(1'b1, 2'($urandom_range(0, 3)));
    check("frame_start_single", 32'(frame_start), 0);
    check("bars_x0_uo", 32'(uo_pmod), 32'h88);
    seg_end("track_frame0");

    for (int i = 0; i < NV; i++) begin
      goto(tbl[i].f, tbl[i].x, tbl[i].y);
      step(1'b1, 2'($urandom_range(0, 3)));
      check($sformatf("pattern_f%0d_x%0d_y%0d", tbl[i].f, tbl[i].x, tbl[i].y),
            32'(uo_pmod), 32'(tbl[i].uo));
      seg_end($sformatf("track_vec%0d", i));
    end

    // Stall for 100 cycles mid-line
    goto(3, 300, 2);
    hx = pix_x; hy = pix_y; huo = uo_pmod; hold_bad = 0; fs_seen = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 2'($urandom_range(0, 3)));
      if (pix_x !== hx || pix_y !== hy || uo_pmod !== huo) hold_bad++;
      if (frame_start !== 1'b0) fs_seen++;
    end
    check("hold_at_x", 32'(hx), 300);
    check("hold_changes", 32'(hold_bad), 0);
    check("hold_frame_start", 32'(fs_seen), 0);
    step(1'b1, 2'($urandom_range(0, 3)));
    check("resume_x", 32'(pix_x), 301);
    seg_end("track_hold");

    // Asynchronous reset in the middle of hsync
    goto(3, 700, 2);
    check("pre_reset_hsync_low", 32'(uo_pmod[7]), 0);
    seg_end("track_reset_approach");
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_uo", 32'(uo_pmod), 32'h88);
    check("async_reset_x", 32'(pix_x), 0);
    check("async_reset_y", 32'(pix_y), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 2'd0);
    check("post_reset_x", 32'(pix_x), 1);
    check("post_reset_fs", 32'(frame_start), 0);
    for (int i = 0; i < 20; i++) step(1'b1, 2'($urandom_range(0, 3)));
    seg_end("track_post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_pmod_source.md
Name: vga_pmod_source

Overview:
- Generates standard 640x480@60 VGA timing plus a selectable test pattern.
- Drives it as a packed TinyVGA PMOD byte.
- This is the source end of the PMOD link. It feeds the noise-overlay filter block, which consumes the same bit layout on its ui_in.
- Downstream logic also gets pixel coordinates and a frame-start strobe.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- clk  input  1  pixel clock (25.175 MHz nominal)
- rst_n  input  1  reset; asynchronous, active-low
- enable  input  1  advance timing when high; freeze everything when low
- pattern_sel  input  2  test pattern request: 0 black, 1 colour bars, 2 checker, 3 gradient
- uo_pmod  output  8  {hsync, B0, G0, R0, vsync, B1, G1, R1}, bit 7 down to bit 0
- pix_x  output  10  horizontal counter, 0..H_TOTAL-1
- pix_y  output  10  vertical counter, 0..V_TOTAL-1
- video_active  output  1  high when pix_x<H_ACTIVE and pix_y<V_ACTIVE
- frame_start  output  1  one-cycle strobe at counter wrap to (0,0)

Behaviour:
- Totals and sync windows:
  - H_TOTAL=800, V_TOTAL=525.
  - Hsync is low for h in [656,751]. Vsync is low for v in [490,491]. Both syncs are negative polarity.
- Reset values: pix_x=0, pix_y=0, uo_pmod=8'h88 (syncs inactive high, RGB 0), frame_start=0, pattern latch=0, frame counter=0.
- Counters, on each clk edge with enable=1:
  - h increments; at 799 it wraps to 0 and v increments.
  - v wraps 524 to 0 together with h wrapping.
- enable=0: counters, uo_pmod, pattern latch and frame counter all hold, and frame_start is 0. Resuming continues from the held position.
- uo_pmod is registered. On an enabled edge it takes encode(h,v) of the pre-edge counters, so uo_pmod lags pix_x/pix_y by exactly 1 cycle.
- video_active is decoded combinationally from the counter registers. It is aligned with pix_x/pix_y, not with uo_pmod.
- Outside the active area, RGB in uo_pmod is 0. Syncs are unaffected by pattern.
- frame_start is registered: frame_start <= enable && h==799 && v==524.
  - It is high in the cycle the counters read (0,0) after a wrap.
  - It does not assert on reset release.
- Pattern latch: pattern_sel is sampled only on the wrap edge (same condition as frame_start), so patterns never tear mid-frame. The first frame after reset uses pattern 0 (black).
- Frame counter: 8 bits, increments on the wrap edge, 255 wraps to 0.
- Pattern definitions (2-bit colour channels; {b,b} means both bits equal b):
  - 0: R=G=B=0.
  - 1: bar=pix_x[8:6]; R={bar[2],bar[2]}, G={bar[1],bar[1]}, B={bar[0],bar[0]}. Bar sequence repeats every 512 px.
  - 2: if pix_x[5]^pix_y[5] then all channels 2'b11, else 0.
  - 3: R=pix_x[7:6], G=pix_y[7:6], B=frame_cnt[5:4].
- Packing: bit7=hsync, 6=B[0], 5=G[0], 4=R[0], 3=vsync, 2=B[1], 1=G[1], 0=R[1].
- Reset asserted mid-line or mid-sync: all state returns to reset values immediately (asynchronously). After release, timing restarts at (0,0).

Decomposition:
- Package vga_pkg holds:
  - timing constants and H_TOTAL/V_TOTAL;
  - the pattern_e enum (PAT_BLACK, PAT_BARS, PAT_CHECK, PAT_GRAD);
  - PMOD bit-index constants.
- Sub-module vga_timing holds the h/v counters, sync decode, video_active and the wrap flag.
- The top level holds the pattern latch, frame counter, colour generation and PMOD packing register.

Test Plan:
- Reset release, enable=1 -> uo_pmod=8'h88 until the first edge; frame_start=0 for the first 420000 cycles, then a single-cycle pulse with pix_x=0, pix_y=0.
- Hsync timing -> bit7 first goes low on the 657th enabled edge after reset release, stays low exactly 96 cycles, and repeats every 800 cycles.
- Vsync timing -> bit3 goes low on edge 392001, stays low exactly 1600 cycles, period 420000.
- pattern_sel=1 held through one wrap, then observe the second frame:
  - pix_x=70 -> uo_pmod=8'hCC;
  - pix_x=450 -> 8'hFF;
  - pix_x=0 -> 8'h88;
  - pix_x=645 (blanking) -> 8'h88.
- Change pattern_sel from 1 to 2 mid-frame -> output stays colour bars until the next frame_start. In the following frame, (pix_x,pix_y)=(32,0) gives 8'hFF and (32,32) gives 8'h88.
- enable=0 for 100 cycles at pix_x=300 -> pix_x, pix_y and uo_pmod are constant and frame_start=0; on re-enable pix_x resumes at 301. Assert rst_n=0 during hsync -> uo_pmod=8'h88 immediately, without waiting for a clock edge.
